btn_pulse_gen: RTL and testbench

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

---
 rtl/btn_pulse_gen.sv | 127 ++++++++++++
 tb/tb_btn_pulse_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// Debounced push-button to single-cycle pulse generator with optional auto-repeat.
// A 2-flop synchronizer feeds a five-state FSM that shares one cycle counter.
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 5,
    parameter int REPEAT_EN       = 1,
    parameter int CTR_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out,
    output logic held
);

    localparam logic [CTR_W-1:0] DEB_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CTR_W-1:0] DLY_LAST = CTR_W'(REPEAT_DELAY - 1);
    localparam logic [CTR_W-1:0] PER_LAST = CTR_W'(REPEAT_PERIOD - 1);
    localparam logic [CTR_W-1:0] CNT_ONE  = CTR_W'(1);
    localparam bit               RPT_ON   = (REPEAT_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HOLD,
        REPEAT,
        DEB_RELEASE
    } state_t;

    logic             sync1_q;
    logic             btn_s_q;
    state_t           state_q;
    logic [CTR_W-1:0] cnt_q;
    logic             pulse_q;
    logic             held_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            btn_s_q <= sync1_q;
        end
    end

    // A falling btn_s is checked first in every accepted state, so a release
    // always wins over a repeat pulse that would fire on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s_q) begin
                        state_q <= DEB_PRESS;
                        cnt_q   <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!btn_s_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!btn_s_q) begin
                        state_q <= DEB_RELEASE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DLY_LAST) begin
                        // Without auto-repeat the counter parks here instead of wrapping.
                        if (RPT_ON) begin
                            state_q <= REPEAT;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!btn_s_q) begin
                        state_q <= DEB_RELEASE;
                        cnt_q   <= '0;
                    end else if (cnt_q == PER_LAST) begin
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DEB_RELEASE: begin
                    if (btn_s_q) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out = pulse_q;
    assign held      = held_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed press scenarios plus random press/release runs,
// compared cycle by cycle against a run-length model, with and without auto-repeat.
module tb_btn_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic btn_in = 1'b0;
    logic pulse_out, held;
    logic pulse_nr, held_nr;

    int n_chk  = 0;
    int n_fail = 0;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1), .CTR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .pulse_out(pulse_out), .held(held)
    );

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0), .CTR_W(16)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn_in(btn_in), .pulse_out(pulse_nr), .held(held_nr)
    );

    always #5 clk = ~clk;

    // Model: index 0 = auto-repeat enabled, index 1 = single pulse per press.
    logic s1, s2;
    int   run [2];
    int   lowr[2];
    int   tmr [2];
    bit   acc [2];
    bit   rep [2];
    bit   exp_pulse[2];
    bit   exp_held [2];

    int ecnt, np0, np1, first0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        s1 = 1'b0;
        s2 = 1'b0;
        for (int m = 0; m < 2; m++) begin
            run[m] = 0; lowr[m] = 0; tmr[m] = 0;
            acc[m] = 1'b0; rep[m] = 1'b0;
            exp_pulse[m] = 1'b0; exp_held[m] = 1'b0;
        end
    endtask

    // Acceptance after D+1 consecutive high synchronized samples, release after
    // D+1 consecutive lows; a high during release restarts the repeat delay.
    task automatic model_step(input logic b);
        logic bs;
        bs = s2;
        s2 = s1;
        s1 = b;
        for (int m = 0; m < 2; m++) begin
            exp_pulse[m] = 1'b0;
            if (!acc[m]) begin
                if (bs) begin
                    run[m]++;
                    if (run[m] == D + 1) begin
                        acc[m] = 1'b1; exp_pulse[m] = 1'b1;
                        tmr[m] = 0; rep[m] = 1'b0; lowr[m] = 0;
                    end
                end else begin
                    run[m] = 0;
                end
            end else if (!bs) begin
                lowr[m]++;
                if (lowr[m] == D + 1) begin
                    acc[m] = 1'b0; run[m] = 0;
                end
            end else if (lowr[m] > 0) begin
                lowr[m] = 0; tmr[m] = 0; rep[m] = 1'b0;
            end else begin
                tmr[m]++;
                if (m == 0) begin
                    if (!rep[m] && tmr[m] == RD) begin
                        exp_pulse[m] = 1'b1; tmr[m] = 0; rep[m] = 1'b1;
                    end else if (rep[m] && tmr[m] == RP) begin
                        exp_pulse[m] = 1'b1; tmr[m] = 0;
                    end
                end
            end
            exp_held[m] = acc[m];
        end
    endtask

    task automatic cyc(input logic b);
        btn_in = b;
        @(posedge clk);
        model_step(b);
        ecnt++;
        @(negedge clk);
        check("pulse", {31'd0, pulse_out}, {31'd0, exp_pulse[0]});
        check("held", {31'd0, held}, {31'd0, exp_held[0]});
        check("pulse_nr", {31'd0, pulse_nr}, {31'd0, exp_pulse[1]});
        check("held_nr", {31'd0, held_nr}, {31'd0, exp_held[1]});
        if (pulse_out) begin
            np0++;
            if (first0 == 0) first0 = ecnt;
        end
        if (pulse_nr) np1++;
    endtask

    task automatic start_seg();
        ecnt = 0; np0 = 0; np1 = 0; first0 = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         found;
        bit   [4:0] pat;
        logic       lvl;
        int         len;

        model_reset();
        start_seg();
        #1 rst = 1'b1;
        #2;
        check("rst_pulse", {31'd0, pulse_out}, 32'd0);
        check("rst_held", {31'd0, held}, 32'd0);
        check("rst_pulse_nr", {31'd0, pulse_nr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean press of 38 cycles
        repeat (3) cyc(1'b0);
        start_seg();
        repeat (38) cyc(1'b1);
        repeat (12) cyc(1'b0);
        check("clean_first_edge", first0, 7);
        check("clean_npulse", np0, 6);
        check("clean_npulse_nr", np1, 1);

        // Bounce that never debounces
        start_seg();
        pat = 5'b10110;
        for (int i = 4; i >= 0; i--) cyc(pat[i]);
        repeat (10) cyc(1'b0);
        check("bounce_npulse", np0, 0);
        check("bounce_npulse_nr", np1, 0);

        // Release with a 2-cycle glitch
        start_seg();
        repeat (8) cyc(1'b1);
        repeat (2) cyc(1'b0);
        repeat (2) cyc(1'b1);
        repeat (10) cyc(1'b0);
        check("glitch_npulse", np0, 1);
        check("glitch_npulse_nr", np1, 1);

        // Asynchronous reset while auto-repeating
        start_seg();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1);
            if (ecnt >= 12 && exp_pulse[0]) begin
                found = 1'b1;
                break;
            end
        end
        check("rpt_seen", {31'd0, found}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_pulse", {31'd0, pulse_out}, 32'd0);
        check("arst_held", {31'd0, held}, 32'd0);
        check("arst_held_nr", {31'd0, held_nr}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_seg();
        repeat (10) cyc(1'b1);
        check("post_rst_first_edge", first0, 7);
        repeat (12) cyc(1'b0);

        // Random press/release runs
        lvl = 1'b0;
        repeat (150) begin
            lvl = ~lvl;
            len = $urandom_range(1, 14);
            repeat (len) cyc(lvl);
        end
        repeat (12) cyc(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
